// File: rtl/inst_decode_ctrl.sv
// Multi-cycle instruction decode controller: latches one instruction per handshake and
// walks it through DECODE/EXEC/WB, presenting immediate fields, register addresses and enables.
module inst_decode_ctrl #(
    parameter int DataSize   = 32,
    parameter int AddrSize   = 5,
    parameter int ExecCycles = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_valid,
    output logic                inst_ready,
    input  logic [DataSize-1:0] inst,
    output logic [4:0]          imm_5bit,
    output logic [13:0]         imm_14bit,
    output logic [14:0]         imm_15bit,
    output logic [19:0]         imm_20bit,
    output logic [23:0]         imm_24bit,
    output logic [2:0]          imm_select,
    output logic [AddrSize-1:0] rt_addr,
    output logic [AddrSize-1:0] ra_addr,
    output logic [AddrSize-1:0] rb_addr,
    output logic [4:0]          alu_op,
    output logic                src2_is_imm,
    output logic                enable_execute,
    output logic                enable_writeback,
    output logic                illegal,
    output logic                busy
);

    localparam int CntW = (ExecCycles > 1) ? $clog2(ExecCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ExecCycles - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DataSize-1:0] ir_q;
    logic [2:0]          imm_sel_q, dec_sel;
    logic [4:0]          alu_op_q, dec_alu;
    logic                src2_q, dec_src2;
    logic                wr_rt_q, dec_wr;
    logic                illegal_q, dec_ill;
    logic                accept;

    assign accept = inst_valid && (state_q == S_IDLE);

    always_comb begin
        dec_sel  = 3'b000;
        dec_alu  = 5'b00000;
        dec_src2 = 1'b0;
        dec_wr   = 1'b0;
        dec_ill  = 1'b0;
        case (ir_q[30:25])
            6'b100000: begin
                dec_alu = ir_q[4:0];
                dec_wr  = 1'b1;
                // Shift/rotate-immediate subops take the 5-bit shift amount as operand 2
                if (ir_q[4:0] == 5'b01000 || ir_q[4:0] == 5'b01001 || ir_q[4:0] == 5'b01011)
                    dec_src2 = 1'b1;
            end
            6'b101000: begin dec_sel = 3'b001; dec_alu = 5'b00000; dec_src2 = 1'b1; dec_wr = 1'b1; end
            6'b101100: begin dec_sel = 3'b010; dec_alu = 5'b00100; dec_src2 = 1'b1; dec_wr = 1'b1; end
            6'b101011: begin dec_sel = 3'b010; dec_alu = 5'b00011; dec_src2 = 1'b1; dec_wr = 1'b1; end
            6'b100010: begin dec_sel = 3'b011; dec_alu = 5'b11111; dec_src2 = 1'b1; dec_wr = 1'b1; end
            6'b100110: dec_sel = 3'b100;
            6'b100100: dec_sel = 3'b101;
            default:   dec_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:   if (inst_valid) state_d = S_DECODE;
            S_DECODE: begin
                state_d = S_EXEC;
                cnt_d   = '0;
            end
            S_EXEC: begin
                if (cnt_q == CntLast) state_d = S_WB;
                else                  cnt_d   = cnt_q + 1'b1;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ir_q      <= '0;
            imm_sel_q <= '0;
            alu_op_q  <= '0;
            src2_q    <= 1'b0;
            wr_rt_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                ir_q      <= inst;
                illegal_q <= 1'b0;
            end
            // Decoded controls are captured once and held stable through WB
            if (state_q == S_DECODE) begin
                imm_sel_q <= dec_sel;
                alu_op_q  <= dec_alu;
                src2_q    <= dec_src2;
                wr_rt_q   <= dec_wr;
                illegal_q <= dec_ill;
            end
        end
    end

    assign imm_5bit         = ir_q[14:10];
    assign imm_14bit        = ir_q[13:0];
    assign imm_15bit        = ir_q[14:0];
    assign imm_20bit        = ir_q[19:0];
    assign imm_24bit        = ir_q[23:0];
    assign rt_addr          = ir_q[24:20];
    assign ra_addr          = ir_q[19:15];
    assign rb_addr          = ir_q[14:10];
    assign imm_select       = imm_sel_q;
    assign alu_op           = alu_op_q;
    assign src2_is_imm      = src2_q;
    assign illegal          = illegal_q;
    assign inst_ready       = (state_q == S_IDLE);
    assign busy             = (state_q != S_IDLE);
    assign enable_execute   = (state_q == S_EXEC) && !illegal_q;
    assign enable_writeback = (state_q == S_WB) && wr_rt_q && !illegal_q;

endmodule

// File: tb/tb_inst_decode_ctrl.sv
// Directed bench for inst_decode_ctrl: each task drives one scenario and checks outputs cycle by cycle.
module tb_inst_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [4:0]  imm_5bit;
    logic [13:0] imm_14bit;
    logic [14:0] imm_15bit;
    logic [19:0] imm_20bit;
    logic [23:0] imm_24bit;
    logic [2:0]  imm_select;
    logic [4:0]  rt_addr, ra_addr, rb_addr, alu_op;
    logic        src2_is_imm, enable_execute, enable_writeback, illegal, busy;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] ADDI = 32'h5030_FFFF;
    localparam logic [31:0] MOVI = 32'h4428_0000;
    localparam logic [31:0] JMP  = 32'h4880_0000;
    localparam logic [31:0] BAD  = 32'h7E00_0000;

    inst_decode_ctrl #(.DataSize(32), .AddrSize(5), .ExecCycles(1)) dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .imm_5bit(imm_5bit), .imm_14bit(imm_14bit), .imm_15bit(imm_15bit),
        .imm_20bit(imm_20bit), .imm_24bit(imm_24bit), .imm_select(imm_select),
        .rt_addr(rt_addr), .ra_addr(ra_addr), .rb_addr(rb_addr), .alu_op(alu_op),
        .src2_is_imm(src2_is_imm), .enable_execute(enable_execute),
        .enable_writeback(enable_writeback), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_inst(input logic [31:0] w);
        inst_valid = 1'b1;
        inst = w;
        tick();
        inst_valid = 1'b0;
        inst = 32'h0;
    endtask

    task automatic test_reset();
        logic [128:0] others;
        rst = 1'b1; inst_valid = 1'b0; inst = 32'hFFFF_FFFF;
        tick(); tick();
        others = {imm_5bit, imm_14bit, imm_15bit, imm_20bit, imm_24bit, imm_select, rt_addr,
                  ra_addr, rb_addr, alu_op, src2_is_imm, enable_execute, enable_writeback, illegal};
        n_cmp++; if (inst_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", inst_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (others !== '0) begin n_bad++; $display("FAIL reset_outputs got %h want 0", others); end
        rst = 1'b0;
    endtask

    task automatic test_addi();
        accept_inst(ADDI);
        n_cmp++; if ({busy, inst_ready, enable_execute, enable_writeback} !== 4'b1000) begin n_bad++; $display("FAIL addi_decode_ctl got %b want 1000", {busy, inst_ready, enable_execute, enable_writeback}); end
        tick();
        n_cmp++; if (imm_select !== 3'b001) begin n_bad++; $display("FAIL addi_sel got %b want 001", imm_select); end
        n_cmp++; if (imm_15bit !== 15'h7FFF) begin n_bad++; $display("FAIL addi_imm15 got %h want 7fff", imm_15bit); end
        n_cmp++; if ({rt_addr, ra_addr} !== {5'd3, 5'd1}) begin n_bad++; $display("FAIL addi_addr got rt=%0d ra=%0d want rt=3 ra=1", rt_addr, ra_addr); end
        n_cmp++; if ({alu_op, src2_is_imm} !== 6'b000001) begin n_bad++; $display("FAIL addi_alu got op=%b imm=%b want 00000/1", alu_op, src2_is_imm); end
        n_cmp++; if ({enable_execute, enable_writeback} !== 2'b10) begin n_bad++; $display("FAIL addi_exec got %b want 10", {enable_execute, enable_writeback}); end
        tick();
        n_cmp++; if ({enable_execute, enable_writeback} !== 2'b01) begin n_bad++; $display("FAIL addi_wb got %b want 01", {enable_execute, enable_writeback}); end
        tick();
        n_cmp++; if ({inst_ready, busy, enable_writeback} !== 3'b100) begin n_bad++; $display("FAIL addi_idle got %b want 100", {inst_ready, busy, enable_writeback}); end
    endtask

    task automatic test_movi();
        accept_inst(MOVI);
        tick();
        n_cmp++; if (imm_select !== 3'b011) begin n_bad++; $display("FAIL movi_sel got %b want 011", imm_select); end
        n_cmp++; if (imm_20bit !== 20'h80000) begin n_bad++; $display("FAIL movi_imm20 got %h want 80000", imm_20bit); end
        n_cmp++; if ({rt_addr, alu_op, src2_is_imm} !== {5'd2, 5'b11111, 1'b1}) begin n_bad++; $display("FAIL movi_ctl got rt=%0d op=%b imm=%b want 2/11111/1", rt_addr, alu_op, src2_is_imm); end
        tick();
        n_cmp++; if (enable_writeback !== 1'b1) begin n_bad++; $display("FAIL movi_wb got %b want 1", enable_writeback); end
        tick();
    endtask

    task automatic test_jump();
        accept_inst(JMP);
        tick();
        n_cmp++; if (imm_select !== 3'b101) begin n_bad++; $display("FAIL j_sel got %b want 101", imm_select); end
        n_cmp++; if (imm_24bit !== 24'h800000) begin n_bad++; $display("FAIL j_imm24 got %h want 800000", imm_24bit); end
        n_cmp++; if (enable_execute !== 1'b1) begin n_bad++; $display("FAIL j_exec got %b want 1", enable_execute); end
        tick();
        n_cmp++; if (enable_writeback !== 1'b0) begin n_bad++; $display("FAIL j_no_wb got %b want 0", enable_writeback); end
        tick();
    endtask

    task automatic test_illegal();
        accept_inst(BAD);
        tick();
        n_cmp++; if ({illegal, imm_select, enable_execute} !== 5'b1_000_0) begin n_bad++; $display("FAIL ill_exec got %b want 10000", {illegal, imm_select, enable_execute}); end
        tick();
        n_cmp++; if (enable_writeback !== 1'b0) begin n_bad++; $display("FAIL ill_no_wb got %b want 0", enable_writeback); end
        tick();
        n_cmp++; if ({illegal, inst_ready} !== 2'b11) begin n_bad++; $display("FAIL ill_sticky got %b want 11", {illegal, inst_ready}); end
        tick();
        n_cmp++; if (illegal !== 1'b1) begin n_bad++; $display("FAIL ill_sticky2 got %b want 1", illegal); end
        accept_inst(ADDI);
        n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL ill_clear got %b want 0", illegal); end
        tick(); tick(); tick();
    endtask

    task automatic test_rst_in_exec();
        int wbs = 0;
        accept_inst(ADDI);
        tick();
        n_cmp++; if (enable_execute !== 1'b1) begin n_bad++; $display("FAIL rstx_in_exec got %b want 1", enable_execute); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if ({inst_ready, busy, enable_execute, enable_writeback} !== 4'b1000) begin n_bad++; $display("FAIL rstx_idle got %b want 1000", {inst_ready, busy, enable_execute, enable_writeback}); end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (enable_writeback) wbs++;
        end
        n_cmp++; if (wbs !== 0) begin n_bad++; $display("FAIL rstx_no_wb got %0d want 0", wbs); end
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        int wbs = 0;
        inst_valid = 1'b1;
        inst = ADDI;
        for (int i = 0; i < 4; i++) begin
            if (inst_ready) accepts++;
            tick();
            inst = MOVI;
            if (enable_writeback) wbs++;
        end
        inst_valid = 1'b0;
        n_cmp++; if (accepts !== 1) begin n_bad++; $display("FAIL b2b_accepts got %0d want 1", accepts); end
        n_cmp++; if (wbs !== 1) begin n_bad++; $display("FAIL b2b_wbs got %0d want 1", wbs); end
        n_cmp++; if (imm_15bit !== 15'h7FFF) begin n_bad++; $display("FAIL b2b_ir_hold got %h want 7fff", imm_15bit); end
        tick();
        n_cmp++; if ({inst_ready, busy} !== 2'b10) begin n_bad++; $display("FAIL b2b_idle got %b want 10", {inst_ready, busy}); end
    endtask

    initial begin
        rst = 1'b1;
        inst_valid = 1'b0;
        inst = 32'h0;
        test_reset();
        test_addi();
        test_movi();
        test_jump();
        test_illegal();
        test_rst_in_exec();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
